// File: rtl/arith_pkg.sv
// Shared encodings for the sequential arithmetic unit: opcodes, FSM states,
// flag bit positions and a flag-packing helper.
package arith_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_NEG   = 2;
  localparam int FLAG_OVF   = 3;
  localparam int NUM_FLAGS  = 4;

  function automatic logic [NUM_FLAGS-1:0] pack_flags(
    input logic carry,
    input logic zero,
    input logic neg,
    input logic ovf
  );
    logic [NUM_FLAGS-1:0] f;
    f             = '0;
    f[FLAG_CARRY] = carry;
    f[FLAG_ZERO]  = zero;
    f[FLAG_NEG]   = neg;
    f[FLAG_OVF]   = ovf;
    return f;
  endfunction

endpackage

// File: rtl/arith_addsub.sv
// Purpose: WIDTH-bit b + a (sub=0) or b + ~a + 1 (sub=1), with carry-out and signed overflow.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module arith_addsub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] a_eff;
  logic [WIDTH:0]   full;

  assign a_eff = sub ? ~a : a;
  assign full  = {1'b0, b} + {1'b0, a_eff} + {{WIDTH{1'b0}}, sub};
  assign sum   = full[WIDTH-1:0];
  assign cout  = full[WIDTH];

  // Overflow on the effective addition: like-signed addends, result sign flipped.
  assign ovf = (b[WIDTH-1] == a_eff[WIDTH-1]) && (sum[WIDTH-1] != b[WIDTH-1]);

endmodule

// File: rtl/sequential_arith_unit.sv
// Purpose: registered ADD/SUB/CMP and shift-add unsigned MUL with a Start/Busy/Done handshake.
// Latency: Done in the cycle after EXEC; EXEC is 1 cycle (ADD/SUB/CMP, MUL when MUL_EN=0) or WIDTH cycles (MUL).
// Backpressure: Start is accepted only in IDLE; requests while Busy are dropped, not queued.
module sequential_arith_unit
  import arith_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             EnableAlu,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] IB_Alu,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Carry,
  output logic             Zero,
  output logic             Neg,
  output logic             Ovf
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]           state_q;
  logic [1:0]           op_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     acc_hi_q;
  logic [WIDTH-1:0]     mq_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     result_q;
  logic [WIDTH-1:0]     result_hi_q;
  logic [NUM_FLAGS-1:0] flags_q;

  logic             is_mul;
  logic             as_sub;
  logic [WIDTH-1:0] as_a;
  logic [WIDTH-1:0] as_b;
  logic [WIDTH-1:0] as_sum;
  logic             as_cout;
  logic             as_ovf;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic             exec_last;

  assign is_mul = (op_q == OP_MUL);
  assign as_sub = (op_q == OP_SUB) || (op_q == OP_CMP);

  // During MUL the adder accumulates the multiplicand into the high half
  // whenever the current multiplier LSB is set.
  always_comb begin
    as_b = b_q;
    as_a = a_q;
    if (is_mul) begin
      as_b = acc_hi_q;
      as_a = mq_q[0] ? a_q : '0;
    end
  end

  arith_addsub #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (as_sub),
    .sum (as_sum),
    .cout(as_cout),
    .ovf (as_ovf)
  );

  assign mul_hi    = {as_cout, as_sum[WIDTH-1:1]};
  assign mul_lo    = {as_sum[0], mq_q[WIDTH-1:1]};
  assign exec_last = !is_mul || !MUL_EN || (cnt_q == CNT_LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      acc_hi_q    <= '0;
      mq_q        <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            op_q     <= Op;
            a_q      <= A;
            b_q      <= B;
            acc_hi_q <= '0;
            mq_q     <= B;
            cnt_q    <= '0;
            state_q  <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (is_mul && MUL_EN) begin
            acc_hi_q <= mul_hi;
            mq_q     <= mul_lo;
            cnt_q    <= cnt_q + CNT_ONE;
          end
          if (exec_last) begin
            state_q <= ST_DONE;
            case (op_q)
              OP_ADD, OP_SUB: begin
                result_q    <= as_sum;
                result_hi_q <= '0;
                flags_q     <= pack_flags(as_cout, ~|as_sum, as_sum[WIDTH-1], as_ovf);
              end
              OP_CMP: begin
                flags_q <= pack_flags(as_cout, ~|as_sum, as_sum[WIDTH-1], as_ovf);
              end
              default: begin
                // With MUL disabled the op completes without touching state.
                if (MUL_EN) begin
                  result_q    <= mul_lo;
                  result_hi_q <= mul_hi;
                  flags_q     <= pack_flags(|mul_hi, ~|{mul_hi, mul_lo}, 1'b0, 1'b0);
                end
              end
            endcase
          end
        end

        ST_DONE: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Busy     = (state_q != ST_IDLE);
  assign Done     = (state_q == ST_DONE);
  assign IB_Alu   = EnableAlu ? result_q : '0;
  assign ResultHi = result_hi_q;
  assign Carry    = flags_q[FLAG_CARRY];
  assign Zero     = flags_q[FLAG_ZERO];
  assign Neg      = flags_q[FLAG_NEG];
  assign Ovf      = flags_q[FLAG_OVF];

endmodule

// File: tb/tb_sequential_arith_unit.sv
// Scoreboard bench: drivers queue expected results, negedge monitors compare on Done.
module tb_sequential_arith_unit;
  import arith_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=4, MUL enabled
  logic       start4, en4, busy4, done4, c4, z4, n4, v4;
  logic [1:0] op4;
  logic [3:0] a4, b4, ib4, hi4;

  // WIDTH=8, MUL disabled
  logic       start8, en8, busy8, done8, c8, z8, n8, v8;
  logic [1:0] op8;
  logic [7:0] a8, b8, ib8, hi8;

  sequential_arith_unit #(.WIDTH(4), .MUL_EN(1'b1)) dut4 (
    .Clk(clk), .Reset(rst), .Start(start4), .Op(op4), .A(a4), .B(b4),
    .EnableAlu(en4), .Busy(busy4), .Done(done4), .IB_Alu(ib4),
    .ResultHi(hi4), .Carry(c4), .Zero(z4), .Neg(n4), .Ovf(v4)
  );

  sequential_arith_unit #(.WIDTH(8), .MUL_EN(1'b0)) dut8 (
    .Clk(clk), .Reset(rst), .Start(start8), .Op(op8), .A(a8), .B(b8),
    .EnableAlu(en8), .Busy(busy8), .Done(done8), .IB_Alu(ib8),
    .ResultHi(hi8), .Carry(c8), .Zero(z8), .Neg(n8), .Ovf(v8)
  );

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       c, z, n, v;
    int         done_at;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  exp_t e4, e8;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done4) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w4_unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e4 = q4.pop_front();
        chk("w4_result", ib4, e4.lo);
        chk("w4_result_hi", hi4, e4.hi);
        chk("w4_carry", c4, e4.c);
        chk("w4_zero", z4, e4.z);
        chk("w4_neg", n4, e4.n);
        chk("w4_ovf", v4, e4.v);
        chk("w4_done_cycle", cyc, e4.done_at);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w8_unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e8 = q8.pop_front();
        chk("w8_result", ib8, e8.lo);
        chk("w8_result_hi", hi8, e8.hi);
        chk("w8_carry", c8, e8.c);
        chk("w8_zero", z8, e8.z);
        chk("w8_neg", n8, e8.n);
        chk("w8_ovf", v8, e8.v);
        chk("w8_done_cycle", cyc, e8.done_at);
      end
    end
  end

  // Issue one op on the 4-bit unit at the first idle negedge; returns at the
  // negedge following the accepting edge with Start already dropped.
  task automatic go4(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] lo, input logic [3:0] hi,
                     input logic c, input logic z, input logic n, input logic v,
                     input bit push);
    int   t;
    exp_t x;
    t = 0;
    @(negedge clk);
    while (busy4 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL w4_busy_timeout actual=busy required=idle");
    end
    op4 = op; a4 = a; b4 = b; start4 = 1'b1;
    if (push) begin
      x.lo = {4'h0, lo}; x.hi = {4'h0, hi};
      x.c = c; x.z = z; x.n = n; x.v = v;
      x.done_at = cyc + 1 + ((op == OP_MUL) ? 4 : 1);
      q4.push_back(x);
    end
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic go8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] lo, input logic [7:0] hi,
                     input logic c, input logic z, input logic n, input logic v);
    int   t;
    exp_t x;
    t = 0;
    @(negedge clk);
    while (busy8 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL w8_busy_timeout actual=busy required=idle");
    end
    op8 = op; a8 = a; b8 = b; start8 = 1'b1;
    x.lo = lo; x.hi = hi; x.c = c; x.z = z; x.n = n; x.v = v;
    x.done_at = cyc + 2;
    q8.push_back(x);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int t;
    rst = 1'b1;
    start4 = 1'b0; op4 = OP_ADD; a4 = '0; b4 = '0; en4 = 1'b1;
    start8 = 1'b0; op8 = OP_ADD; a8 = '0; b8 = '0; en8 = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy4, 0);
    chk("reset_done", done4, 0);
    chk("reset_bus", ib4, 0);
    chk("reset_flags", {c4, z4, n4, v4}, 0);
    rst = 1'b0;

    go4(OP_ADD, 4'h7, 4'h9, 4'h0, 4'h0, 1, 1, 0, 0, 1);
    go4(OP_SUB, 4'h3, 4'h2, 4'hF, 4'h0, 0, 0, 1, 0, 1);
    go4(OP_CMP, 4'h5, 4'h5, 4'hF, 4'h0, 1, 1, 0, 0, 1);

    // Start held with changing operands while the MUL runs; all dropped.
    go4(OP_MUL, 4'h3, 4'h5, 4'hF, 4'h0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      start4 = 1'b1; op4 = 2'(k); a4 = 4'(k + 9); b4 = 4'(12 - k);
      @(negedge clk);
    end
    start4 = 1'b0;

    go4(OP_MUL, 4'hF, 4'hF, 4'h1, 4'hE, 1, 0, 0, 0, 1);
    busy_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      busy_cnt += int'(busy4);
      @(negedge clk);
    end
    chk("mul_busy_cycles", busy_cnt, 5);

    // Abandon a MUL in its second EXEC cycle.
    go4(OP_MUL, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy4, 0);
    chk("midrst_done", done4, 0);
    chk("midrst_bus", ib4, 0);
    chk("midrst_hi", hi4, 0);
    chk("midrst_flags", {c4, z4, n4, v4}, 0);
    @(negedge clk);
    rst = 1'b0;

    go4(OP_ADD, 4'h5, 4'h6, 4'hB, 4'h0, 0, 0, 1, 1, 1);
    t = 0;
    while (busy4 && t < 20) begin
      @(negedge clk);
      t++;
    end
    for (int k = 0; k < 2; k++) begin
      en4 = 1'b0;
      #1 chk("bus_gate_off", ib4, 0);
      en4 = 1'b1;
      #1 chk("bus_gate_on", ib4, 4'hB);
    end

    go4(OP_ADD, 4'h8, 4'h8, 4'h0, 4'h0, 1, 1, 0, 1, 1);
    go4(OP_SUB, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 0, 0, 1);
    go4(OP_MUL, 4'h0, 4'hF, 4'h0, 4'h0, 0, 1, 0, 0, 1);
    go4(OP_SUB, 4'h1, 4'h8, 4'h7, 4'h0, 1, 0, 0, 1, 1);

    go8(OP_ADD, 8'h40, 8'h50, 8'h90, 8'h00, 0, 0, 1, 1);
    go8(OP_MUL, 8'h03, 8'h05, 8'h90, 8'h00, 0, 0, 1, 1);
    go8(OP_SUB, 8'h01, 8'h80, 8'h7F, 8'h00, 1, 0, 0, 1);
    go8(OP_MUL, 8'hFF, 8'hFF, 8'h7F, 8'h00, 1, 0, 0, 1);

    t = 0;
    while ((q4.size() != 0 || q8.size() != 0 || busy4 || busy8) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0 pending", q4.size() + q8.size());
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
